// File: rtl/result_pkg.sv
// result_pkg: word indices, record layout and default widths shared by the result buffer slice.
package result_pkg;
    localparam int COORD_W      = 12;
    localparam int CAND_W       = 5;
    localparam int RECORD_WORDS = 3;

    localparam logic [1:0] WORD_X    = 2'd0;
    localparam logic [1:0] WORD_Y    = 2'd1;
    localparam logic [1:0] WORD_CAND = 2'd2;

    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [CAND_W-1:0]  cand;
    } record_t;
endpackage

// File: rtl/result_buffer_if.sv
// result_buffer_if: record write port, serial word read port and status flags of the result buffer.
interface result_buffer_if #(
    parameter int COORD_WIDTH = 12,
    parameter int NUM_RESIZE  = 5,
    parameter int DEPTH       = 64,
    parameter int OUT_WIDTH   = 12
);
    logic                       wr_valid;
    logic                       wr_ready;
    logic [COORD_WIDTH-1:0]     wr_x;
    logic [COORD_WIDTH-1:0]     wr_y;
    logic [NUM_RESIZE-1:0]      wr_cand;
    logic                       rd_valid;
    logic                       rd_ready;
    logic [OUT_WIDTH-1:0]       rd_data;
    logic                       rd_last;
    logic [$clog2(DEPTH):0]     count;
    logic                       empty;
    logic                       full;
    logic                       overflow;
    logic                       clr_overflow;

    modport master (
        output wr_valid, wr_x, wr_y, wr_cand, rd_ready, clr_overflow,
        input  wr_ready, rd_valid, rd_data, rd_last, count, empty, full, overflow
    );

    modport slave (
        input  wr_valid, wr_x, wr_y, wr_cand, rd_ready, clr_overflow,
        output wr_ready, rd_valid, rd_data, rd_last, count, empty, full, overflow
    );
endinterface

// File: rtl/result_storage.sv
// result_storage: record array with one synchronous write port and one asynchronous read port.
module result_storage #(
    parameter int WIDTH = 29,
    parameter int DEPTH = 64
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/result_buffer.sv
// result_buffer: FIFO of detection records drained as x, y, cand words over valid/ready.
// Optional RESULT_BUFFER_FILTER_EN accepts but discards records with an empty candidate mask.
module result_buffer
    import result_pkg::*;
#(
    parameter int COORD_WIDTH = 12,
    parameter int NUM_RESIZE  = 5,
    parameter int DEPTH       = 64,
    parameter int OUT_WIDTH   = 12
) (
    input  logic           clk,
    input  logic           reset,
    result_buffer_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int RW = 2 * COORD_WIDTH + NUM_RESIZE;

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    w_q, w_d;
    logic          ovf_q, ovf_d;
    logic          full, empty, wr_ready, keep, push, store, adv, pop;
    logic [RW-1:0] rec;
    logic [OUT_WIDTH-1:0] word;

`ifdef RESULT_BUFFER_FILTER_EN
    assign keep = |bus.wr_cand;
`else
    assign keep = 1'b1;
`endif

    result_storage #(.WIDTH(RW), .DEPTH(DEPTH)) u_storage (
        .clk     (clk),
        .we_i    (store),
        .waddr_i (tail_q),
        .wdata_i ({bus.wr_x, bus.wr_y, bus.wr_cand}),
        .raddr_i (head_q),
        .rdata_o (rec)
    );

    always_comb begin
        full     = count_q == CW'(DEPTH);
        empty    = count_q == '0;
        wr_ready = !full && !reset;
        push     = bus.wr_valid && wr_ready;
        store    = push && keep;
        adv      = !empty && bus.rd_ready;
        pop      = adv && (w_q == 2'(RECORD_WORDS - 1));
        w_d      = adv ? (pop ? WORD_X : w_q + 2'd1) : w_q;
        head_d   = head_q + PW'(pop);
        tail_d   = tail_q + PW'(store);
        count_d  = count_q + CW'(store) - CW'(pop);
        // a refused write outranks a same-cycle clear
        ovf_d    = (bus.wr_valid && full && keep) || (ovf_q && !bus.clr_overflow);
        word     = (w_q == WORD_X) ? OUT_WIDTH'(rec[RW-1 -: COORD_WIDTH]) :
                   (w_q == WORD_Y) ? OUT_WIDTH'(rec[NUM_RESIZE +: COORD_WIDTH]) :
                                     OUT_WIDTH'(rec[NUM_RESIZE-1:0]);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            w_q     <= WORD_X;
            ovf_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            w_q     <= w_d;
            ovf_q   <= ovf_d;
        end
    end

    assign bus.wr_ready = wr_ready;
    assign bus.rd_valid = !empty;
    assign bus.rd_data  = empty ? '0 : word;
    assign bus.rd_last  = !empty && (w_q == WORD_CAND);
    assign bus.count    = count_q;
    assign bus.empty    = empty;
    assign bus.full     = full;
    assign bus.overflow = ovf_q;
endmodule

// File: tb/tb_result_buffer.sv
// tb_result_buffer: directed and random stimulus against a queue-of-records reference model.
module tb_result_buffer;
    import result_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    result_buffer_if bus();
    result_buffer dut (.clk(clk), .reset(reset), .bus(bus));

    int total = 0;
    int bad = 0;
    record_t mq[$];
    int widx = 0;
    bit movf = 1'b0;
    logic [11:0] obs_data;
    logic [6:0]  obs_count;
    logic obs_last, obs_valid, obs_ovf, obs_full, obs_wr_ready;
    int nlast;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [11:0] exp_word();
        if (mq.size() == 0) return 12'd0;
        return widx == 0 ? mq[0].x : widx == 1 ? mq[0].y : 12'(mq[0].cand);
    endfunction

    task automatic cyc(input bit rst, input bit wv, input logic [11:0] x, input logic [11:0] y,
                       input logic [4:0] c, input bit rr, input bit clr);
        bit is_full, keep;
        reset = rst;
        bus.wr_valid = wv;
        bus.wr_x = x;
        bus.wr_y = y;
        bus.wr_cand = c;
        bus.rd_ready = rr;
        bus.clr_overflow = clr;
        @(negedge clk);
        is_full = mq.size() == 64;
        check("wr_ready", bus.wr_ready, !is_full && !rst);
        check("rd_valid", bus.rd_valid, mq.size() != 0);
        check("rd_data", bus.rd_data, exp_word());
        check("rd_last", bus.rd_last, mq.size() != 0 && widx == 2);
        check("count", bus.count, mq.size());
        check("empty", bus.empty, mq.size() == 0);
        check("full", bus.full, is_full);
        check("overflow", bus.overflow, movf);
        obs_data = bus.rd_data;
        obs_last = bus.rd_last;
        obs_valid = bus.rd_valid;
        obs_count = bus.count;
        obs_ovf = bus.overflow;
        obs_full = bus.full;
        obs_wr_ready = bus.wr_ready;
        @(posedge clk);
`ifdef RESULT_BUFFER_FILTER_EN
        keep = c != 0;
`else
        keep = 1'b1;
`endif
        if (rst) begin
            mq.delete();
            widx = 0;
            movf = 1'b0;
        end else begin
            if (wv && is_full && keep) movf = 1'b1;
            else if (clr) movf = 1'b0;
            if (mq.size() != 0 && rr) begin
                if (widx == 2) begin
                    void'(mq.pop_front());
                    widx = 0;
                end else widx++;
            end
            if (wv && !is_full && keep) mq.push_back('{x, y, c});
        end
        #1;
    endtask

    task automatic idle(input bit rr);
        cyc(1'b0, 1'b0, 12'd0, 12'd0, 5'd0, rr, 1'b0);
    endtask

    task automatic wr(input logic [11:0] x, input logic [11:0] y, input logic [4:0] c, input bit rr);
        cyc(1'b0, 1'b1, x, y, c, rr, 1'b0);
    endtask

    initial begin
        bus.wr_valid = 1'b0;
        bus.wr_x = '0;
        bus.wr_y = '0;
        bus.wr_cand = '0;
        bus.rd_ready = 1'b0;
        bus.clr_overflow = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        cyc(1'b1, 1'b1, 12'd1, 12'd2, 5'd3, 1'b1, 1'b0);
        check("rst_wr_ready", obs_wr_ready, 1'b0);

        // single record
        wr(12'd100, 12'd50, 5'b00100, 1'b0);
        check("t1_wr_ready", obs_wr_ready, 1'b1);
        idle(1'b1);
        check("t1_valid", obs_valid, 1'b1);
        check("t1_x", obs_data, 12'd100);
        idle(1'b1);
        check("t1_y", obs_data, 12'd50);
        check("t1_nolast", obs_last, 1'b0);
        idle(1'b1);
        check("t1_cand", obs_data, 12'd4);
        check("t1_last", obs_last, 1'b1);
        idle(1'b0);
        check("t1_empty", obs_valid, 1'b0);

        // fill, overflow, clear
        for (int i = 0; i < 64; i++) wr(12'($urandom), 12'($urandom), 5'($urandom_range(1, 31)), 1'b0);
        idle(1'b0);
        check("t2_full", obs_full, 1'b1);
        check("t2_wr_ready", obs_wr_ready, 1'b0);
        wr(12'd1, 12'd2, 5'd3, 1'b0);
        idle(1'b0);
        check("t2_ovf", obs_ovf, 1'b1);
        check("t2_count", obs_count, 7'd64);
        cyc(1'b0, 1'b0, 12'd0, 12'd0, 5'd0, 1'b0, 1'b1);
        idle(1'b0);
        check("t2_ovf_clr", obs_ovf, 1'b0);

        // stall mid-record on the y word
        idle(1'b1);
        for (int i = 0; i < 5; i++) begin
            idle(1'b0);
            check("t3_hold_y", obs_data, mq[0].y);
            check("t3_hold_last", obs_last, 1'b0);
        end
        idle(1'b1);
        idle(1'b1);
        check("t3_resume_last", obs_last, 1'b1);
        for (int i = 0; i < 189; i++) idle(1'b1);
        idle(1'b0);
        check("t3_drained", obs_valid, 1'b0);

        // push concurrent with final-word pop
        for (int i = 0; i < 3; i++) wr(12'(i + 10), 12'(i + 20), 5'd1, 1'b0);
        idle(1'b1);
        idle(1'b1);
        wr(12'd40, 12'd41, 5'd2, 1'b1);
        idle(1'b0);
        check("t4_count", obs_count, 7'd3);
        for (int i = 0; i < 9; i++) idle(1'b1);

        // zero-mask records
        wr(12'd7, 12'd8, 5'd0, 1'b0);
        wr(12'd9, 12'd10, 5'b10001, 1'b0);
        idle(1'b0);
`ifdef RESULT_BUFFER_FILTER_EN
        check("t5_count", obs_count, 7'd1);
`else
        check("t5_count", obs_count, 7'd2);
`endif
        nlast = 0;
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            nlast += int'(obs_last);
        end
`ifdef RESULT_BUFFER_FILTER_EN
        check("t5_records", nlast, 1);
`else
        check("t5_records", nlast, 2);
`endif

        // reset mid-record
        for (int i = 0; i < 4; i++) wr(12'(i + 200), 12'(i + 300), 5'd4, 1'b0);
        idle(1'b1);
        cyc(1'b1, 1'b0, 12'd0, 12'd0, 5'd0, 1'b0, 1'b0);
        idle(1'b0);
        check("t6_count", obs_count, 7'd0);
        check("t6_valid", obs_valid, 1'b0);
        check("t6_data", obs_data, 12'd0);
        wr(12'h123, 12'h45, 5'd1, 1'b0);
        idle(1'b1);
        check("t6_x", obs_data, 12'h123);

        // random traffic, heavy then draining
        for (int i = 0; i < 1500; i++) begin
            bit heavy;
            heavy = i < 900;
            cyc($urandom_range(0, 299) == 0,
                heavy ? $urandom_range(0, 3) != 0 : $urandom_range(0, 3) == 0,
                12'($urandom), 12'($urandom),
                $urandom_range(0, 3) == 0 ? 5'd0 : 5'($urandom),
                heavy ? $urandom_range(0, 2) != 0 : $urandom_range(0, 7) != 0,
                $urandom_range(0, 30) == 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/result_buffer.md
# result_buffer

Collects face-detection hits from the classifier and holds each hit as one atomic record: x origin, y origin, and the per-scale candidate mask. Records drain to the host/bus side as a three-word serial stream under a valid/ready handshake. The block sits between the Haar cascade window controller and the result transmit path. It accepts a full record in one cycle and reports fill level, empty, full and overflow.

## Interface
- COORD_WIDTH, 12, width of x and y coordinates
- NUM_RESIZE, 5, number of resize scales; width of candidate mask
- DEPTH, 64, record capacity; power of two, ≥2
- OUT_WIDTH, 12, output word width; must be ≥ max(COORD_WIDTH, NUM_RESIZE)

Ports:
- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- wr_valid  in  1  record present on wr_x/wr_y/wr_cand
- wr_ready  out  1  buffer can accept a record this cycle
- wr_x  in  COORD_WIDTH  window origin x
- wr_y  in  COORD_WIDTH  window origin y
- wr_cand  in  NUM_RESIZE  bit i set = hit at scale i
- rd_valid  out  1  rd_data holds a valid word
- rd_ready  in  1  consumer takes the word
- rd_data  out  OUT_WIDTH  serialised word, zero-extended
- rd_last  out  1  current word is the final (candidate) word of a record
- count  out  $clog2(DEPTH)+1  records stored, including the one being drained
- empty  out  1  count == 0
- full  out  1  count == DEPTH
- overflow  out  1  sticky: a write was attempted while full
- clr_overflow  in  1  clears overflow

## Operation
- Push occurs when wr_valid && wr_ready. The record is written at the tail, and the tail pointer wraps modulo DEPTH.
- wr_ready = !full && !reset. There is no pass-through: a write while full is refused even if a pop completes in the same cycle.
- A write attempt while full drops the record and sets overflow. Overflow is cleared only by reset or clr_overflow. If a set event and clr_overflow occur in the same cycle, the set wins.
- The read side uses a word index register w in {0,1,2}. rd_data word order is w=0 x, w=1 y, w=2 cand, each zero-extended to OUT_WIDTH.
- A word advances on rd_valid && rd_ready. At w=2 the record pops, the head wraps, and w returns to 0.
- rd_valid = !empty. rd_last = rd_valid && (w == 2).
- Simultaneous push and pop leave count unchanged. A push alone increments count; a pop alone decrements it.
- While rd_valid is high and rd_ready is low, rd_data and rd_last remain stable.

## Timing
- Reset values: rd_valid=0, rd_data=0, rd_last=0, count=0, empty=1, full=0, overflow=0, wr_ready=0 (during reset), w=0, and both pointers 0.
- wr_ready goes to 1 in the first cycle after reset deasserts.
- Write-to-read latency: a record pushed at edge N produces rd_valid=1 with word x in cycle N+1.
- Sustained throughput is one word per cycle, so one record per three cycles.
- All outputs come from registers or from a mux of registered state. There is no combinational path from wr_* or rd_ready to any output except wr_ready, which depends only on full and reset.
- count, empty and full update on the edge that performs the push or pop.
- Reset asserted mid-record discards all contents and the partial read. There is no recovery of the partially drained record.

## Configuration
- RESULT_BUFFER_FILTER_EN defined: records with wr_cand == 0 are accepted (wr_ready behaves normally) but not stored. They change neither count nor overflow.
- Not defined: every accepted record is stored, regardless of wr_cand.

## Structure
- Shared package result_pkg holds:
  - word index constants WORD_X=0, WORD_Y=1, WORD_CAND=2
  - RECORD_WORDS=3
  - a packed record typedef (x, y, cand) parameterised via localparams from COORD_WIDTH/NUM_RESIZE defaults
- Sub-module result_storage: a DEPTH-entry record array with one synchronous write port and one asynchronous read port addressed by head. It holds no control logic.
- result_buffer holds the pointers, count, word index, handshake and overflow logic.

## Test plan
- Reset, then one write (x=100, y=50, cand=5'b00100) → rd_valid next cycle; words 100, 50, 4; rd_last on the third word; empty=1 afterwards.
- Fill to 64 records with rd_ready=0 → full=1, wr_ready=0; one more wr_valid → record dropped, overflow=1; clr_overflow → overflow=0.
- Hold rd_ready=0 for 5 cycles mid-record at w=1 → rd_data stays equal to y and rd_last=0; release → continues with cand.
- Simultaneous push and final-word pop at count=3 → count stays 3; FIFO order preserved across pointer wrap after 70 records.
- With the macro defined, write cand=0 then cand=5'b10001 → only the second record is emitted and count peaks at 1. Without the macro, both records are emitted.
- Assert reset at w=1 with 4 records stored → next cycle count=0, rd_valid=0, rd_data=0; a new write yields a clean x-first record.
